// File: rtl/fifo_write_arbiter.sv
// Round-robin packet arbiter sharing one 512x9 FWFT FIFO write port between NumReq byte streams.
// Define FIFO_ARB_HEADER_EN to emit a per-packet header word instead of a start-of-packet flag.
module fifo_write_arbiter #(
    parameter int unsigned NumReq  = 4,
    parameter int unsigned IdWidth = 2
) (
    input  logic                  Clk,
    input  logic                  ResetN,
    input  logic [NumReq-1:0]     ReqValid,
    input  logic [8*NumReq-1:0]   ReqData,
    input  logic [NumReq-1:0]     ReqLast,
    output logic [NumReq-1:0]     ReqReady,
    output logic [NumReq-1:0]     Grant,
    output logic [8:0]            FifoDin,
    output logic                  FifoWrite,
    input  logic                  FifoFull,
    input  logic                  FifoProgFull,
    output logic                  Busy,
    output logic [15:0]           PktCount
);

    localparam int unsigned PktWidth = 16;

`ifdef FIFO_ARB_HEADER_EN
    localparam logic SopEn = 1'b0;
`else
    localparam logic SopEn = 1'b1;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
`ifdef FIFO_ARB_HEADER_EN
        S_HDR  = 2'd2,
`endif
        S_DATA = 2'd1
    } state_e;

    state_e                state_q, state_d;
    logic [NumReq-1:0]     grant_q, grant_d;
    logic [IdWidth-1:0]    cur_id_q, cur_id_d;
    logic [IdWidth-1:0]    last_id_q, last_id_d;
    logic [PktWidth-1:0]   pkt_cnt_q, pkt_cnt_d;
    logic                  first_q, first_d;

    logic                  arb_found;
    logic [IdWidth-1:0]    arb_id;
    logic [IdWidth-1:0]    cand;
    logic [7:0]            cur_byte;

    // Rotating-priority search starting one past the previous owner.
    always_comb begin
        arb_found = 1'b0;
        arb_id    = '0;
        cand      = '0;
        for (int unsigned k = 1; k <= NumReq; k++) begin
            cand = IdWidth'((32'(last_id_q) + k) % NumReq);
            if (!arb_found && ReqValid[cand]) begin
                arb_found = 1'b1;
                arb_id    = cand;
            end
        end
    end

    assign cur_byte = ReqData[{cur_id_q, 3'b000} +: 8];

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            state_q   <= S_IDLE;
            grant_q   <= '0;
            cur_id_q  <= '0;
            last_id_q <= IdWidth'(NumReq - 1);
            pkt_cnt_q <= '0;
            first_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            cur_id_q  <= cur_id_d;
            last_id_q <= last_id_d;
            pkt_cnt_q <= pkt_cnt_d;
            first_q   <= first_d;
        end
    end

    // Next-state and write-port outputs; the grant is locked until the last byte.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        cur_id_d  = cur_id_q;
        last_id_d = last_id_q;
        pkt_cnt_d = pkt_cnt_q;
        first_d   = first_q;
        ReqReady  = '0;
        FifoWrite = 1'b0;
        FifoDin   = 9'h000;

        case (state_q)
            S_IDLE: begin
                if (arb_found && !FifoProgFull) begin
                    grant_d  = NumReq'(1) << arb_id;
                    cur_id_d = arb_id;
                    first_d  = 1'b1;
`ifdef FIFO_ARB_HEADER_EN
                    state_d  = S_HDR;
`else
                    state_d  = S_DATA;
`endif
                end
            end
`ifdef FIFO_ARB_HEADER_EN
            S_HDR: begin
                if (!FifoFull) begin
                    FifoWrite = 1'b1;
                    FifoDin   = {1'b1, 5'b00000, 3'(cur_id_q)};
                    state_d   = S_DATA;
                end
            end
`endif
            S_DATA: begin
                ReqReady[cur_id_q] = !FifoFull;
                if (ReqValid[cur_id_q] && !FifoFull) begin
                    FifoWrite = 1'b1;
                    FifoDin   = {first_q & SopEn, cur_byte};
                    first_d   = 1'b0;
                    if (ReqLast[cur_id_q]) begin
                        state_d   = S_IDLE;
                        grant_d   = '0;
                        last_id_d = cur_id_q;
                        pkt_cnt_d = pkt_cnt_q + PktWidth'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign Grant    = grant_q;
    assign PktCount = pkt_cnt_q;
    assign Busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Scoreboard bench for fifo_write_arbiter: expected FIFO words are queued by the
// stimulus and popped by an independent monitor on every FifoWrite.
module tb_fifo_write_arbiter;

`ifdef FIFO_ARB_HEADER_EN
    localparam bit HdrEn = 1'b1;
    localparam int NumG  = 13;
`else
    localparam bit HdrEn = 1'b0;
    localparam int NumG  = 9;
`endif

    logic        Clk = 1'b0;
    logic        ResetN;
    logic [3:0]  ReqValid;
    logic [31:0] ReqData;
    logic [3:0]  ReqLast;
    logic [3:0]  ReqReady;
    logic [3:0]  Grant;
    logic [8:0]  FifoDin;
    logic        FifoWrite;
    logic        FifoFull;
    logic        FifoProgFull;
    logic        Busy;
    logic [15:0] PktCount;

    int          errors = 0;
    int          checks = 0;
    logic [8:0]  exp_q[$];
    logic [7:0]  pkt_bytes[$];
    logic [15:0] exp_pkt;
    int          exp_g[NumG];

    fifo_write_arbiter #(.NumReq(4), .IdWidth(2)) dut (
        .Clk(Clk), .ResetN(ResetN),
        .ReqValid(ReqValid), .ReqData(ReqData), .ReqLast(ReqLast),
        .ReqReady(ReqReady), .Grant(Grant),
        .FifoDin(FifoDin), .FifoWrite(FifoWrite),
        .FifoFull(FifoFull), .FifoProgFull(FifoProgFull),
        .Busy(Busy), .PktCount(PktCount)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting for DUT at %0t", name, $time);
    endtask

    // Monitor: every write must match the head of the expectation queue.
    always @(negedge Clk) begin
        if (FifoWrite) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL fifo_word: got %0h expected no write at %0t", FifoDin, $time);
            end else begin
                logic [8:0] e;
                e = exp_q.pop_front();
                if (FifoDin !== e) begin
                    errors++;
                    $display("FAIL fifo_word: got %0h expected %0h at %0t", FifoDin, e, $time);
                end
            end
        end else begin
            checks++;
            if (FifoDin !== 9'h000) begin
                errors++;
                $display("FAIL idle_din: got %0h expected 0 at %0t", FifoDin, $time);
            end
        end
    end

    task automatic push_pkt(input int id, input int n);
        if (HdrEn) exp_q.push_back({1'b1, 5'b00000, 3'(id)});
        for (int i = 0; i < n; i++)
            exp_q.push_back({(i == 0) && !HdrEn, pkt_bytes[i]});
    endtask

    // Drives pkt_bytes from requester id; called just after a rising edge.
    task automatic send_pkt(input int id);
        int n;
        n = pkt_bytes.size();
        push_pkt(id, n);
        for (int i = 0; i < n; i++) begin
            bit acc;
            int budget;
            acc = 1'b0;
            budget = 50;
            ReqValid[id]       = 1'b1;
            ReqData[8*id +: 8] = pkt_bytes[i];
            ReqLast[id]        = (i == n - 1);
            while (!acc && budget > 0) begin
                @(negedge Clk);
                acc = ReqReady[id];
                @(posedge Clk);
                #1;
                budget--;
            end
            if (!acc) timeout_fail("send_pkt");
        end
        ReqValid[id] = 1'b0;
        ReqLast[id]  = 1'b0;
        exp_pkt++;
    endtask

    // Called at a falling edge; retires accepted beats until no request remains.
    task automatic drain();
        logic [3:0] acc;
        int budget;
        budget = 60;
        while (budget > 0) begin
            acc = ReqReady & ReqValid;
            @(posedge Clk);
            #1;
            ReqValid = ReqValid & ~acc;
            ReqLast  = ReqLast & ~acc;
            if (ReqValid == 4'b0000) break;
            @(negedge Clk);
            budget--;
        end
        if (ReqValid != 4'b0000) timeout_fail("drain");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] acc;
`ifdef FIFO_ARB_HEADER_EN
        exp_g = '{0, 1, 1, 0, 2, 2, 0, 4, 4, 0, 8, 8, 0};
`else
        exp_g = '{0, 1, 0, 2, 0, 4, 0, 8, 0};
`endif
        ResetN = 1'b0; ReqValid = '0; ReqData = '0; ReqLast = '0;
        FifoFull = 1'b0; FifoProgFull = 1'b0; exp_pkt = '0;

        // Reset state.
        repeat (2) @(negedge Clk);
        chk("rst_grant", 32'(Grant), 0);
        chk("rst_busy", 32'(Busy), 0);
        chk("rst_pkt", 32'(PktCount), 0);
        chk("rst_ready", 32'(ReqReady), 0);
        chk("rst_write", 32'(FifoWrite), 0);
        @(posedge Clk); #1 ResetN = 1'b1;
        @(posedge Clk); #1;

        // All four requesters at once, single-byte packets.
        for (int i = 0; i < 4; i++) begin
            ReqData[8*i +: 8] = 8'(8'hA0 + i);
            if (HdrEn) exp_q.push_back({1'b1, 5'b00000, 3'(i)});
            exp_q.push_back({!HdrEn, 8'(8'hA0 + i)});
        end
        ReqValid = 4'hF; ReqLast = 4'hF;
        for (int k = 0; k < NumG; k++) begin
            @(negedge Clk);
            chk($sformatf("rr_grant[%0d]", k), 32'(Grant), 32'(exp_g[k]));
            acc = ReqReady & ReqValid;
            @(posedge Clk); #1;
            ReqValid = ReqValid & ~acc;
            ReqLast  = ReqLast & ~acc;
        end
        chk("rr_all_served", 32'(ReqValid), 0);
        exp_pkt = 16'd4;
        @(negedge Clk);
        chk("rr_pkt", 32'(PktCount), 32'(exp_pkt));
        @(posedge Clk); #1;

        // Single requester, three bytes.
        pkt_bytes = '{8'h11, 8'h22, 8'h33};
        send_pkt(0);
        @(negedge Clk);
        chk("single_pkt", 32'(PktCount), 32'(exp_pkt));
        chk("single_grant", 32'(Grant), 0);
        chk("single_busy", 32'(Busy), 0);
        @(posedge Clk); #1;

        // FifoFull stall mid-packet; ProgFull raised too and must be ignored.
        pkt_bytes = '{8'h40, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45};
        fork
            send_pkt(1);
            begin
                repeat (3) @(posedge Clk);
                #1 FifoFull = 1'b1; FifoProgFull = 1'b1;
                for (int c = 0; c < 5; c++) begin
                    @(negedge Clk);
                    chk("stall_ready", 32'(ReqReady), 0);
                    chk("stall_write", 32'(FifoWrite), 0);
                    chk("stall_grant", 32'(Grant), 32'h2);
                    @(posedge Clk); #1;
                end
                FifoFull = 1'b0; FifoProgFull = 1'b0;
                @(negedge Clk);
                chk("stall_resume", 32'(ReqReady), 32'h2);
            end
        join
        @(negedge Clk);
        chk("stall_pkt", 32'(PktCount), 32'(exp_pkt));
        @(posedge Clk); #1;

        // ProgFull gating in IDLE.
        FifoProgFull = 1'b1;
        ReqValid[2] = 1'b1; ReqData[23:16] = 8'h5C; ReqLast[2] = 1'b1;
        pkt_bytes = '{8'h5C};
        push_pkt(2, 1);
        for (int c = 0; c < 4; c++) begin
            @(negedge Clk);
            chk("pf_nogrant", 32'(Grant), 0);
            chk("pf_idle", 32'(Busy), 0);
            @(posedge Clk); #1;
        end
        FifoProgFull = 1'b0;
        @(negedge Clk);
        chk("pf_fall_cycle", 32'(Grant), 0);
        @(posedge Clk); #1;
        @(negedge Clk);
        chk("pf_grant", 32'(Grant), 32'h4);
        drain();
        exp_pkt++;
        @(negedge Clk);
        chk("pf_pkt", 32'(PktCount), 32'(exp_pkt));
        @(posedge Clk); #1;

        // Reset mid-packet after two data bytes.
        begin
            int accn;
            int budget;
            bit a;
            accn = 0; budget = 50;
            ReqValid[3] = 1'b1; ReqData[31:24] = 8'h70; ReqLast[3] = 1'b0;
            if (HdrEn) exp_q.push_back(9'h103);
            exp_q.push_back({!HdrEn, 8'h70});
            exp_q.push_back({1'b0, 8'h71});
            while (accn < 2 && budget > 0) begin
                @(negedge Clk);
                a = ReqReady[3];
                @(posedge Clk); #1;
                if (a) begin
                    accn++;
                    ReqData[31:24] = 8'(8'h70 + accn);
                end
                budget--;
            end
            if (accn < 2) timeout_fail("rst_mid_setup");
        end
        chk("mid_busy_before", 32'(Busy), 1);
        #2 ResetN = 1'b0;
        #1;
        chk("mid_rst_grant", 32'(Grant), 0);
        chk("mid_rst_busy", 32'(Busy), 0);
        chk("mid_rst_pkt", 32'(PktCount), 0);
        chk("mid_rst_ready", 32'(ReqReady), 0);
        chk("mid_rst_write", 32'(FifoWrite), 0);
        chk("mid_rst_din", 32'(FifoDin), 0);
        ReqValid = '0; ReqLast = '0; exp_pkt = '0;
        @(posedge Clk); #1 ResetN = 1'b1;
        @(posedge Clk); #1;

        // After reset, requester 0 beats requester 3.
        ReqData[7:0] = 8'hC0; ReqData[31:24] = 8'hC3;
        ReqValid = 4'b1001; ReqLast = 4'b1001;
        pkt_bytes = '{8'hC0}; push_pkt(0, 1);
        pkt_bytes = '{8'hC3}; push_pkt(3, 1);
        @(negedge Clk);
        chk("prio_idle", 32'(Grant), 0);
        @(posedge Clk); #1;
        @(negedge Clk);
        chk("prio_grant0", 32'(Grant), 32'h1);
        drain();
        exp_pkt = 16'd2;
        @(negedge Clk);
        chk("prio_pkt", 32'(PktCount), 32'(exp_pkt));
        @(posedge Clk); #1;

        // Counter wrap: preload near the top, then complete two packets.
        force dut.pkt_cnt_q = 16'hFFFE;
        #1 release dut.pkt_cnt_q;
        exp_pkt = 16'hFFFE;
        @(posedge Clk); #1;
        pkt_bytes = '{8'h99};
        send_pkt(1);
        @(negedge Clk);
        chk("wrap_ffff", 32'(PktCount), 32'(exp_pkt));
        @(posedge Clk); #1;
        send_pkt(2);
        @(negedge Clk);
        chk("wrap_zero", 32'(PktCount), 0);
        @(posedge Clk); #1;

        repeat (3) @(negedge Clk);
        chk("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
